// File: rtl/fetch_unit_pkg.sv
// Shared sizing for the instruction fetch unit: default address/word widths and
// the depth of the fetched-instruction buffer.
package fetch_unit_pkg;

   localparam int FETCH_ADDR_W    = 10;
   localparam int FETCH_WORD_W    = 20;
   localparam int FETCH_BUF_DEPTH = 2;
   localparam int FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

   typedef logic [FETCH_CNT_W-1:0] buf_cnt_t;
   typedef logic [FETCH_CNT_W:0]   credit_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: RAM read port, redirect input and instruction valid/ready output.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int WORD_W = FETCH_WORD_W
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ld;
   logic [WORD_W-1:0] mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [WORD_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output mem_addr, mem_ld, inst_valid, inst, inst_pc,
      input  mem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  mem_addr, mem_ld, inst_valid, inst, inst_pc,
      output mem_rdata, redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry {pc,word} FIFO with push, pop, flush and occupancy count.
// Slot 0 is always the head entry.
module fetch_buf
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int WORD_W = FETCH_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [WORD_W-1:0] push_word,
   output buf_cnt_t          count,
   output logic [ADDR_W-1:0] head_pc,
   output logic [WORD_W-1:0] head_word
);

   logic [ADDR_W-1:0] pc_reg   [FETCH_BUF_DEPTH];
   logic [WORD_W-1:0] word_reg [FETCH_BUF_DEPTH];
   buf_cnt_t          count_reg;
   logic              full;
   logic              do_pop;
   logic              do_push;
   buf_cnt_t          wr_slot;

   assign full    = (count_reg == buf_cnt_t'(FETCH_BUF_DEPTH));
   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && (!full || do_pop);
   assign wr_slot = count_reg - buf_cnt_t'(do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
            pc_reg[i]   <= '0;
            word_reg[i] <= '0;
         end
      end else if (flush) begin
         count_reg <= '0;
      end else begin
         // The head only advances when a second entry waits behind it, so an
         // emptied buffer keeps presenting the last instruction.
         if (do_pop && full) begin
            pc_reg[0]   <= pc_reg[1];
            word_reg[0] <= word_reg[1];
         end
         if (do_push) begin
            pc_reg[wr_slot[0]]   <= push_pc;
            word_reg[wr_slot[0]] <= push_word;
         end
         count_reg <= count_reg + buf_cnt_t'(do_push) - buf_cnt_t'(do_pop);
      end
   end

   assign count     = count_reg;
   assign head_pc   = pc_reg[0];
   assign head_word = word_reg[0];

endmodule

// File: rtl/fetch_unit.sv
// Read-only instruction fetch: issues one RAM read per cycle under a credit
// limit, buffers responses with their pc, and flushes on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                WORD_W   = FETCH_WORD_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [ADDR_W-1:0] req_pc_reg;
   logic              inflight_reg;
   buf_cnt_t          count;
   logic [ADDR_W-1:0] head_pc;
   logic [WORD_W-1:0] head_word;
   logic              valid;
   logic              pop;
   logic              push;
   logic              issue;
   credit_t           credit;

   assign valid  = !rst && (count != '0);
   assign pop    = valid && bus.inst_ready;
   // Entries held plus the one in flight, less the one leaving this cycle.
   assign credit = credit_t'(count) + credit_t'(inflight_reg) - credit_t'(pop);
   assign issue  = !rst && !bus.redirect && (credit < credit_t'(FETCH_BUF_DEPTH));
   assign push   = !rst && !bus.redirect && inflight_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= RESET_PC;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (bus.redirect) begin
            fetch_pc_reg <= bus.redirect_pc;
         end else if (issue) begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(1);
            req_pc_reg   <= fetch_pc_reg;
         end
      end
   end

   fetch_buf #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect),
      .push      (push),
      .pop       (pop),
      .push_pc   (req_pc_reg),
      .push_word (bus.mem_rdata),
      .count     (count),
      .head_pc   (head_pc),
      .head_word (head_word)
   );

   assign bus.mem_ld     = issue;
   assign bus.mem_addr   = rst ? RESET_PC : fetch_pc_reg;
   assign bus.inst_valid = valid;
   assign bus.inst       = rst ? '0 : head_word;
   assign bus.inst_pc    = rst ? '0 : head_pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'd0, first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 10, RAM word-address width (1024 words).
REQ-003 SHALL have parameter WORD_W, default 20, instruction/RAM word width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port: clk  input  1  clock; all state updates on posedge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: mem_addr  output  ADDR_W  RAM word address.
REQ-008 Port: mem_ld  output  1  RAM read request; exactly one read per asserted cycle.
REQ-009 Port: mem_rdata  input  WORD_W  RAM read data, valid the cycle after the request.
REQ-010 Port: redirect  input  1  branch/jump redirect strobe.
REQ-011 Port: redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1.
REQ-012 Port: inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-013 Port: inst_ready  input  1  consumer accepts the instruction; pop = inst_valid & inst_ready.
REQ-014 Port: inst  output  WORD_W  head instruction word.
REQ-015 Port: inst_pc  output  ADDR_W  address inst was fetched from.
REQ-016 SHALL never drive RAM write or store; the block is read-only.

Function
REQ-017 SHALL keep fetch_pc, a 2-entry {pc,word} buffer, and a 1-bit inflight flag.
REQ-018 Credit rule: SHALL assert mem_ld when !redirect && (count + inflight - pop) < 2.
REQ-019 When mem_ld=1: mem_addr=fetch_pc, inflight set, fetch_pc increments by 1 at the edge.
REQ-020 fetch_pc SHALL wrap 1023 -> 0 without a stall.
REQ-021 When mem_ld=0: mem_addr SHALL hold fetch_pc; inflight cleared at the edge.
REQ-022 Response: cycle after an issue, mem_rdata SHALL be pushed with its request pc; inst_valid rises the following cycle.
REQ-023 Latency: issue at cycle c -> inst_valid at c+2; steady-state throughput one instruction per cycle with inst_ready held high.
REQ-024 Buffer is FIFO; inst/inst_pc SHALL be the oldest entry; simultaneous push and pop SHALL be legal at any count.
REQ-025 Full (count=2): no issue until pop; buffer SHALL never overflow.
REQ-026 Empty: inst_valid=0, inst and inst_pc hold their last values.
REQ-027 Redirect cycle N: mem_ld=0; a response arriving in cycle N SHALL be discarded; buffer flushed at the edge; fetch_pc := redirect_pc.
REQ-028 Redirect and pop in the same cycle: pop counts as accepted, then flush.
REQ-029 After redirect at N: mem_ld with mem_addr=redirect_pc at N+1, inst_valid with inst_pc=redirect_pc at N+3.
REQ-030 Back-to-back redirects: last one wins; each restarts REQ-029 timing.

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC, count=0, inflight=0, mem_ld=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
REQ-032 rst SHALL dominate redirect and any in-flight response; a response landing in the first cycle after reset is discarded.
REQ-033 First cycle with rst=0: mem_ld=1, mem_addr=RESET_PC.

Structure
REQ-034 ADDR_W, WORD_W and buffer depth 2 SHALL live in shared header fetch_defs.vh.
REQ-035 SHALL instantiate one sub-module fetch_buf (2-entry FIFO with push, pop, flush, count); credit logic and fetch_pc stay in fetch_unit.

Verification
REQ-036 Reset then inst_ready=1, RAM[0..3]=101,202,303,404 -> mem_ld at cycles 0..; inst_valid from cycle 2, inst 101,202,303,404 on consecutive cycles, inst_pc 0..3.
REQ-037 inst_ready=0 from reset -> exactly two reads (addr 0,1), then mem_ld=0; buffer holds 101,202; raise ready -> pops in order, fetch resumes at addr 2.
REQ-038 Redirect to 10'd500 while count=2, inflight=1 -> buffer flushed, stale response dropped, mem_addr=500 next cycle, inst_pc=500 two cycles later.
REQ-039 RESET_PC=10'd1022, RAM[1022]=0xABCDE, RAM[1023]=1, RAM[0]=2 -> inst_pc 1022,1023,0 with matching words.
REQ-040 Assert rst with count=2 and inflight=1 -> next cycle inst_valid=0, mem_ld=0; after release fetch restarts at RESET_PC.
